// File: rtl/tri_bus_arbiter.sv
// Round-robin arbiter driving one shared tri-state bus, with turnaround gap and hold limit.
// Define TRI_BUS_ARBITER_KEEPER_EN to hold the last owned value on the bus instead of floating it.
module tri_bus_arbiter #(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned CHANNELS   = 4,
    parameter int unsigned TURNAROUND = 1,
    parameter int unsigned MAX_HOLD   = 16,
    localparam int unsigned OW        = (CHANNELS > 2) ? $clog2(CHANNELS) : 1
) (
    input  logic                      iClk,
    input  logic                      iRst,
    input  logic [CHANNELS-1:0]       iReq,
    input  logic [CHANNELS*WIDTH-1:0] iData,
    output logic [CHANNELS-1:0]       oGnt,
    output wire logic [WIDTH-1:0]     oBus,
    output logic [OW-1:0]             oOwner,
    output logic                      oBusy
);

    localparam int unsigned HW = $clog2(MAX_HOLD + 1);
    localparam int unsigned TW = (TURNAROUND > 1) ? $clog2(TURNAROUND) : 1;

    typedef enum logic [1:0] {StIdle, StOwn, StTurn} state_e;

    state_e              state_q, state_d;
    logic [OW-1:0]       ptr_q, ptr_d;
    logic [HW-1:0]       hold_q, hold_d;
    logic [TW-1:0]       turn_q, turn_d;
    logic [CHANNELS-1:0] gnt_q, gnt_d;
    logic [OW-1:0]       owner_q, owner_d;

    logic                win_valid;
    logic [OW-1:0]       win_idx;
    logic                own_req;
    logic                other_req;
    logic                do_arb;
    logic [WIDTH-1:0]    own_data;

    // First requester at or after ptr, wrapping around.
    always_comb begin
        int unsigned   cand;
        logic [OW-1:0] cand_idx;
        win_valid = 1'b0;
        win_idx   = '0;
        cand      = 0;
        cand_idx  = '0;
        for (int unsigned k = 0; k < CHANNELS; k++) begin
            cand     = (32'(ptr_q) + k) % CHANNELS;
            cand_idx = OW'(cand);
            if (!win_valid && iReq[cand_idx]) begin
                win_valid = 1'b1;
                win_idx   = cand_idx;
            end
        end
    end

    always_comb begin
        own_data = '0;
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            if (owner_q == OW'(i)) begin
                own_data = iData[i*WIDTH +: WIDTH];
            end
        end
    end

    assign own_req   = |(iReq & gnt_q);
    assign other_req = |(iReq & ~gnt_q);

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        hold_d  = hold_q;
        turn_d  = turn_q;
        gnt_d   = gnt_q;
        owner_d = owner_q;
        do_arb  = 1'b0;

        case (state_q)
            StIdle: do_arb = 1'b1;
            StOwn: begin
                if (hold_q != HW'(MAX_HOLD)) begin
                    hold_d = hold_q + 1'b1;
                end
                // Forced release only fires exactly at the limit; a saturated counter never forces.
                if (!own_req || (hold_q == HW'(MAX_HOLD - 1) && other_req)) begin
                    gnt_d = '0;
                    if (TURNAROUND > 0) begin
                        state_d = StTurn;
                        turn_d  = '0;
                    end else begin
                        state_d = StIdle;
                        do_arb  = 1'b1;
                    end
                end
            end
            StTurn: begin
                if (turn_q == TW'(TURNAROUND - 1)) begin
                    state_d = StIdle;
                    do_arb  = 1'b1;
                end else begin
                    turn_d = turn_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase

        if (do_arb && win_valid) begin
            state_d        = StOwn;
            ptr_d          = (win_idx == OW'(CHANNELS - 1)) ? '0 : win_idx + 1'b1;
            hold_d         = '0;
            gnt_d          = '0;
            gnt_d[win_idx] = 1'b1;
            owner_d        = win_idx;
        end
    end

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            state_q <= StIdle;
            ptr_q   <= '0;
            hold_q  <= '0;
            turn_q  <= '0;
            gnt_q   <= '0;
            owner_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            hold_q  <= hold_d;
            turn_q  <= turn_d;
            gnt_q   <= gnt_d;
            owner_q <= owner_d;
        end
    end

    assign oGnt   = gnt_q;
    assign oOwner = owner_q;
    assign oBusy  = (state_q != StIdle);

`ifdef TRI_BUS_ARBITER_KEEPER_EN
    logic [WIDTH-1:0] keep_q, keep_d;

    always_comb begin
        keep_d = keep_q;
        if (state_q == StOwn) begin
            keep_d = own_data;
        end
    end

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            keep_q <= '0;
        end else begin
            keep_q <= keep_d;
        end
    end

    assign oBus = (state_q == StOwn) ? own_data : keep_q;
`else
    assign oBus = (state_q == StOwn) ? own_data : {WIDTH{1'bz}};
`endif

endmodule
